// File: rtl/pw_trigger_pkg.sv
// Shared encodings and default widths for the trigger generator/monitor pair.
// Imported by the monitor top and its synchroniser.
package pw_trigger_pkg;

  localparam int PW_DELAY_WIDTH_DEF = 20;
  localparam int PW_WIDTH_WIDTH_DEF = 17;
  localparam int PW_SYNC_STAGES_DEF = 2;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARMED = 3'd1;
  localparam logic [2:0] ST_DELAY = 3'd2;
  localparam logic [2:0] ST_WIDTH = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_ARMED = ST_ARMED,
    S_DELAY = ST_DELAY,
    S_WIDTH = ST_WIDTH,
    S_DONE  = ST_DONE
  } pw_state_e;

endpackage

// File: rtl/pw_sync_edge.sv
// Multi-flop synchroniser for an asynchronous level, with edge strobes
// derived from the last stage and its one-cycle delay.
module pw_sync_edge
  import pw_trigger_pkg::*;
#(
  parameter int pSYNC_STAGES = PW_SYNC_STAGES_DEF
) (
  input  logic trigger_clk,
  input  logic reset_i,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [pSYNC_STAGES-1:0] sync_q, sync_d;
  logic                    last_q, last_d;

  always_comb begin
    sync_d = {sync_q[pSYNC_STAGES-2:0], async_i};
    last_d = sync_q[pSYNC_STAGES-1];
  end

  always_ff @(posedge trigger_clk or posedge reset_i) begin
    if (reset_i) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      last_q <= last_d;
    end
  end

  assign sync_o = sync_q[pSYNC_STAGES-1];
  assign rise_o = sync_o & ~last_q;
  assign fall_o = ~sync_o & last_q;

endmodule

// File: rtl/pw_trigger_monitor.sv
// Measures match-to-trigger delay and trigger pulse width in trigger_clk
// cycles, posting results to the register block via valid/ack.
module pw_trigger_monitor
  import pw_trigger_pkg::*;
#(
  parameter int pTRIGGER_DELAY_WIDTH = PW_DELAY_WIDTH_DEF,
  parameter int pTRIGGER_WIDTH_WIDTH = PW_WIDTH_WIDTH_DEF,
  parameter int pSYNC_STAGES         = PW_SYNC_STAGES_DEF
) (
  input  logic                            trigger_clk,
  input  logic                            reset_i,
  input  logic                            I_trigger_in,
  input  logic                            I_match,
  input  logic                            I_arm,
  input  logic                            I_abort,
  input  logic [pTRIGGER_DELAY_WIDTH-1:0] I_timeout,
  input  logic                            I_result_ack,
  output logic [pTRIGGER_DELAY_WIDTH-1:0] O_delay,
  output logic [pTRIGGER_WIDTH_WIDTH-1:0] O_width,
  output logic                            O_result_valid,
  output logic                            O_timeout,
  output logic                            O_width_ovf,
  output logic                            O_busy
);

  localparam int DW = pTRIGGER_DELAY_WIDTH;
  localparam int WW = pTRIGGER_WIDTH_WIDTH;

  logic trig_sync, trig_rise, trig_fall;

  pw_sync_edge #(
    .pSYNC_STAGES(pSYNC_STAGES)
  ) u_sync (
    .trigger_clk(trigger_clk),
    .reset_i    (reset_i),
    .async_i    (I_trigger_in),
    .sync_o     (trig_sync),
    .rise_o     (trig_rise),
    .fall_o     (trig_fall)
  );

  pw_state_e      state_q, state_d;
  logic [DW-1:0]  dcnt_q, dcnt_d;
  logic [WW-1:0]  wcnt_q, wcnt_d;
  logic [DW-1:0]  delay_q, delay_d;
  logic [WW-1:0]  width_q, width_d;
  logic           valid_q, valid_d;
  logic           tout_q, tout_d;
  logic           ovf_q, ovf_d;
  logic           busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    wcnt_d  = wcnt_q;
    delay_d = delay_q;
    width_d = width_q;
    valid_d = valid_q;
    tout_d  = tout_q;
    ovf_d   = ovf_q;
    if (I_abort) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (I_arm) begin
            state_d = S_ARMED;
            tout_d  = 1'b0;
            ovf_d   = 1'b0;
          end
        end
        S_ARMED: begin
          if (I_match) begin
            state_d = S_DELAY;
            dcnt_d  = '0;
          end
        end
        S_DELAY: begin
          // A rise on the timeout edge still counts as a real trigger.
          if (trig_rise) begin
            delay_d = dcnt_q;
            wcnt_d  = WW'(1);
            state_d = S_WIDTH;
          end else if (I_timeout != '0 &&
                       dcnt_q == I_timeout - DW'(1)) begin
            delay_d = I_timeout;
            width_d = '0;
            tout_d  = 1'b1;
            valid_d = 1'b1;
            state_d = S_DONE;
          end else if (dcnt_q == '1) begin
            delay_d = '1;
            width_d = '0;
            tout_d  = 1'b1;
            valid_d = 1'b1;
            state_d = S_DONE;
          end else begin
            dcnt_d = dcnt_q + DW'(1);
          end
        end
        S_WIDTH: begin
          // WIDTH only persists while high, so the first low is a fall.
          if (trig_fall) begin
            width_d = wcnt_q;
            valid_d = 1'b1;
            state_d = S_DONE;
          end else if (wcnt_q == '1) begin
            ovf_d = 1'b1;
          end else begin
            wcnt_d = wcnt_q + WW'(1);
          end
        end
        S_DONE: begin
          if (I_result_ack) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge trigger_clk or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      dcnt_q  <= '0;
      wcnt_q  <= '0;
      delay_q <= '0;
      width_q <= '0;
      valid_q <= 1'b0;
      tout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      wcnt_q  <= wcnt_d;
      delay_q <= delay_d;
      width_q <= width_d;
      valid_q <= valid_d;
      tout_q  <= tout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
    end
  end

  assign O_delay        = delay_q;
  assign O_width        = width_q;
  assign O_result_valid = valid_q;
  assign O_timeout      = tout_q;
  assign O_width_ovf    = ovf_q;
  assign O_busy         = busy_q;

endmodule
